nios_system_key_in: RTL and testbench

- Avalon-MM slave input PIO: the read-side counterpart of the colour output PIOs.
- Samples an external WIDTH-bit bus (e.g. button or keycode lines) through a synchronizer.
- Captures edges per bit and raises a maskable level interrupt to the Nios II CPU.
- Sits on the system interconnect beside the output PIOs, in the same 4-word register window.

---
 rtl/nios_system_key_in_pkg.sv | 17 +
 rtl/nios_system_key_in_edge_sync.sv | 54 +++++
 rtl/nios_system_key_in.sv | 89 ++++++++
 tb/tb_nios_system_key_in.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nios_system_key_in_pkg.sv
// Shared definitions for the key-input PIO.
// Holds the register word addresses of the 4-word PIO window and the
// encodings of the EDGE_TYPE capture-mode parameter.
package nios_system_key_in_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    // EDGE_TYPE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_key_in_edge_sync.sv
// Input synchronizer, delay flop and per-bit edge detector.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_port      : asynchronous external inputs (WIDTH bits)
//   sync         : in_port after two synchronizer flops
//   edge_det     : one-cycle pulse per bit on the edge chosen by EDGE_TYPE
module nios_system_edge_sync
    import nios_system_key_in_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter logic [31:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_det
);

    localparam logic [WIDTH-1:0] RST = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] delayed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= RST;
            sync2   <= RST;
            delayed <= RST;
        end else begin
            sync1   <= in_port;
            sync2   <= sync1;
            delayed <= sync2;
        end
    end

    assign rise = sync2 & ~delayed;
    assign fall = ~sync2 & delayed;
    assign sync = sync2;

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_det = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_det = rise | fall;
        end else begin : g_rise
            assign edge_det = rise;
        end
    endgenerate

endmodule

// File: rtl/nios_system_key_in.sv
// Avalon-MM slave input PIO with per-bit edge capture and maskable irq.
//   clk, reset_n : clock, asynchronous active-low reset
//   address      : word address (0 DATA, 1 DIRECTION, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect   : slave select
//   write_n      : active-low write strobe
//   writedata    : write data, bits at and above WIDTH ignored
//   in_port      : asynchronous external inputs
//   readdata     : registered read data, latency 1, no wait states
//   irq          : level interrupt, |(edgecapture & irqmask)
module nios_system_key_in
    import nios_system_key_in_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter logic [31:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr;

    nios_system_edge_sync #(
        .WIDTH      (WIDTH),
        .EDGE_TYPE  (EDGE_TYPE),
        .RESET_VALUE(RESET_VALUE)
    ) u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync    (sync),
        .edge_det(edge_det)
    );

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Edge is OR-ed in after the clear so a coincident new edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
            irqmask     <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clr) | edge_det;
            if (wr && address == ADDR_IRQMASK)
                irqmask <= writedata[WIDTH-1:0];
        end
    end

    // DIRECTION has no storage: an input-only PIO always reads 0 there.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGE:    rd_mux[WIDTH-1:0] = edgecapture;
            default:      ;
        endcase
    end

    // Registered every cycle; the fabric only looks at it one cycle after a read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq = |(edgecapture & irqmask);

    generate
        if (WIDTH < 32) begin : g_upper
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_nios_system_key_in.sv
// Directed bench for nios_system_key_in: a rising-edge instance and an
// any-edge instance share the bus and inputs.
// Inputs change 1 ns after a rising clock edge; outputs are sampled there too.
module tb_nios_system_key_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd, rd_any;
    logic        irq, irq_any;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nios_system_key_in #(.WIDTH(8), .EDGE_TYPE(0), .RESET_VALUE(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd), .irq(irq)
    );

    nios_system_key_in #(.WIDTH(8), .EDGE_TYPE(2), .RESET_VALUE(32'h0)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // After return, rd/rd_any hold the data for address a.
    task automatic rd_reg(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        step();
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        #2;
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_readdata", rd, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(3);
        chk("idle_irq", {31'b0, irq}, 32'h0);

        // DATA read latency
        in_port = 8'hA5;
        step(3);
        rd_reg(2'd0);
        chk("data_read", rd, 32'h0000_00A5);
        address = 2'd1;
        chk("data_hold_before_edge", rd, 32'h0000_00A5);
        step();
        chk("dir_read", rd, 32'h0);
        rd_reg(2'd3);
        chk("edge_rise_a5", rd, 32'h0000_00A5);
        chk("irq_unmasked", {31'b0, irq}, 32'h0);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        in_port = 8'h00;
        step(4);
        rd_reg(2'd3);
        chk("no_fall_capture", rd, 32'h0);
        chk("any_fall_capture", rd_any, 32'h0000_00A5);
        wr_reg(2'd3, 32'hFF);

        // Rising capture with irq
        wr_reg(2'd2, 32'h01);
        in_port = 8'h01;
        step();
        chk("rise_lat_n", {31'b0, irq}, 32'h0);
        step();
        chk("rise_lat_n1", {31'b0, irq}, 32'h0);
        step();
        chk("rise_lat_n2", {31'b0, irq}, 32'h1);
        rd_reg(2'd3);
        chk("rise_edge_reg", rd, 32'h01);
        in_port = 8'h00;
        step(4);
        rd_reg(2'd3);
        chk("rise_after_fall", rd, 32'h01);

        // Write-1-to-clear colliding with a new edge
        in_port = 8'h02;
        step(4);
        rd_reg(2'd3);
        chk("edge_pre_collide", rd, 32'h03);
        in_port = 8'h03;
        step(2);
        wr_reg(2'd3, 32'h01);
        rd_reg(2'd3);
        chk("collide_edge_wins", rd, 32'h03);
        wr_reg(2'd3, 32'h03);
        chk("clear_irq_drop", {31'b0, irq}, 32'h0);
        rd_reg(2'd3);
        chk("clear_all", rd, 32'h0);

        // Mask gating
        wr_reg(2'd2, 32'h00);
        in_port = 8'h83;
        step(4);
        chk("mask_off_irq", {31'b0, irq}, 32'h0);
        rd_reg(2'd3);
        chk("edge_bit7", rd, 32'h80);
        wr_reg(2'd2, 32'h80);
        chk("mask_on_irq", {31'b0, irq}, 32'h1);
        wr_reg(2'd2, 32'h00);
        chk("mask_off_again", {31'b0, irq}, 32'h0);
        wr_reg(2'd2, 32'hFFFF_FF80);
        rd_reg(2'd2);
        chk("mask_upper_ignored", rd, 32'h80);

        // Reset mid-operation
        in_port = 8'h80;
        step(4);
        wr_reg(2'd3, 32'hFF);
        in_port = 8'h85;
        step(4);
        wr_reg(2'd2, 32'hFF);
        rd_reg(2'd3);
        chk("pre_reset_edge", rd, 32'h05);
        chk("pre_reset_irq", {31'b0, irq}, 32'h1);
        #2;
        reset_n = 1'b0;
        in_port = 8'h00;
        #1;
        chk("async_reset_irq", {31'b0, irq}, 32'h0);
        chk("async_reset_rd", rd, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(2);
        rd_reg(2'd0);
        chk("post_reset_data", rd, 32'h0);
        rd_reg(2'd2);
        chk("post_reset_mask", rd, 32'h0);
        rd_reg(2'd3);
        chk("post_reset_edge", rd, 32'h0);

        // Any-edge mode: two separate captures of bit3
        in_port = 8'h08;
        step(4);
        rd_reg(2'd3);
        chk("any_first", rd_any, 32'h08);
        chk("rise_first", rd, 32'h08);
        wr_reg(2'd3, 32'h08);
        rd_reg(2'd3);
        chk("any_cleared", rd_any, 32'h0);
        in_port = 8'h00;
        step(4);
        rd_reg(2'd3);
        chk("any_second", rd_any, 32'h08);
        chk("rise_no_second", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
